// File: rtl/store_pkg.sv
// Shared definitions for the store data path: size encodings, controller
// states and the default memory ack timeout.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } store_state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: drops byte/half store data into the old word.
// Purely combinational so the store-forwarding path can reuse it.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old_word;
    case (i_size)
      SZ_BYTE: o_merged[{i_lane, 3'b000} +: 8]        = i_wdata[7:0];
      SZ_HALF: o_merged[{i_lane[1], 4'b0000} +: 16]   = i_wdata[15:0];
      SZ_WORD: o_merged                               = i_wdata;
      default: o_merged                               = i_old_word;
    endcase
  end

endmodule

// File: rtl/store_data_merger.sv
// Store controller: word stores write directly, byte/half stores do a
// read-modify-write; every memory access is bounded by an ack timeout.
//
// state    | meaning
// ST_IDLE  | waiting for start, busy=0
// ST_READ  | reading the containing word for a byte/half store
// ST_WRITE | writing the merged (or full) word
// ST_DONE  | one-cycle done pulse, err valid
module store_data_merger
  import store_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  store_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;

  logic          w_misaligned;
  logic [31:0]   w_merged;

  assign w_misaligned = (size == SZ_RSVD) ||
                        ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  store_lane_merge u_merge (
    .i_old_word (mem_rdata),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_lane     (r_lane),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_size    <= SZ_BYTE;
      r_lane    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_wdata  <= wdata;
            r_size   <= size;
            r_lane   <= addr[1:0];
            mem_addr <= {addr[31:2], 2'b00};
            r_cnt    <= '0;
            busy     <= 1'b1;
            if (w_misaligned) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (size == SZ_WORD) begin
              r_state   <= ST_WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              r_state <= ST_READ;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            r_state   <= ST_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= w_merged;
            r_cnt     <= '0;
          end else if (r_cnt == CNT_LAST) begin
            // read timed out: abandon without issuing the write
            r_state <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WRITE: begin
          if (mem_ack || (r_cnt == CNT_LAST)) begin
            r_state <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= !mem_ack;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          err     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_data_merger.sv
// Randomized and directed bench for store_data_merger against a
// transaction-level model of the store rules and a behavioural memory.
module tb_store_data_merger;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  store_data_merger #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] sz, input logic [31:0] a);
    int sh;
    case (sz)
      2'd0: begin
        sh = 8 * int'(a % 4);
        return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end
      2'd1: begin
        sh = 16 * int'((a / 2) % 2);
        return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  // One store; rd_wait/wr_wait are wait cycles before ack, >= TO means never ack.
  task automatic run_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                           input int rd_wait, input int wr_wait, input string tag);
    logic        mis, rd_to, exp_err, found, err_seen, seen_write;
    int          idx, exp_rc, exp_wc, exp_done, rc, wc, done_at, ph_cnt, bad, wt;
    logic [31:0] old, exp_word, exp_addr;

    mis      = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && (a % 4) != 0);
    idx      = int'((a / 4) % 256);
    old      = mem[idx];
    exp_addr = a & 32'hFFFF_FFFC;
    if (mis) begin
      exp_rc = 0; exp_wc = 0; exp_err = 1'b1;
    end else begin
      exp_rc  = (sz == 2'd2) ? 0 : ((rd_wait >= TO) ? TO : rd_wait + 1);
      rd_to   = (sz != 2'd2) && (rd_wait >= TO);
      exp_wc  = rd_to ? 0 : ((wr_wait >= TO) ? TO : wr_wait + 1);
      exp_err = rd_to || (!rd_to && wr_wait >= TO);
    end
    exp_word = exp_err ? old : ref_word(old, wd, sz, a);
    exp_done = 1 + exp_rc + exp_wc;

    @(negedge clk);
    addr = a; wdata = wd; size = sz; start = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk);
    rc = 0; wc = 0; ph_cnt = 0; bad = 0; found = 1'b0; done_at = 0; err_seen = 1'b0;
    seen_write = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (!busy) bad++;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (mem_addr !== exp_addr) bad++;
        if (mem_we) begin
          wc++; seen_write = 1'b1;
        end else begin
          rc++;
          if (seen_write) bad++;
        end
        wt = mem_we ? wr_wait : rd_wait;
        if (wt < TO && ph_cnt == wt) begin
          mem_ack = 1'b1;
          ph_cnt  = 0;
          if (mem_we) mem[int'(mem_addr[9:2])] = mem_wdata;
          else mem_rdata = mem[int'(mem_addr[9:2])];
        end else begin
          mem_ack = 1'b0;
          ph_cnt++;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (done) begin
        found = 1'b1; done_at = n; err_seen = err; start = 1'b0;
        break;
      end
      // requests while busy must be dropped, not queued
      start = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));
    end
    start = 1'b0;
    if (!found) chk_eq({tag, " done_seen"}, 32'd0, 32'd1);
    chk_eq({tag, " done_cycle"}, done_at, exp_done);
    chk_eq({tag, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
    chk_eq({tag, " read_cycles"}, rc, exp_rc);
    chk_eq({tag, " write_cycles"}, wc, exp_wc);
    chk_eq({tag, " bus_protocol"}, bad, 0);
    chk_eq({tag, " mem_word"}, mem[idx], exp_word);
    @(negedge clk);
    mem_ack = 1'b0;
    chk_eq({tag, " idle_after"}, {30'd0, busy, mem_req}, 32'd0);
  endtask

  task automatic reset_in_write(input logic [31:0] a);
    int wc, dn;
    @(negedge clk);
    addr = a; wdata = $urandom; size = 2'd0; start = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    wc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      if (mem_req && !mem_we) begin
        mem_ack = 1'b1;
        mem_rdata = mem[int'(mem_addr[9:2])];
      end else if (mem_req && mem_we) begin
        wc++;
        if (wc == 3) begin
          reset = 1'b1;
          break;
        end
      end
    end
    chk_eq("rst_mid reached_write", wc, 3);
    @(negedge clk);
    reset = 1'b0;
    chk_eq("rst_mid outputs", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
    chk_eq("rst_mid mem_addr", mem_addr, 32'd0);
    dn = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      if (done || mem_req) dn++;
    end
    mem_ack = 1'b0;
    chk_eq("rst_mid quiet_after", dn, 0);
  endtask

  initial begin
    int          rw, ww;
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("reset ctrl", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
    chk_eq("reset mem_addr", mem_addr, 32'd0);
    chk_eq("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    run_store(32'h100, 32'hDEADBEEF, 2'd2, 0, 0, "word");
    mem[8'h80] = 32'h11223344;
    run_store(32'h203, 32'h000000AB, 2'd0, 0, 0, "byte");
    chk_eq("byte literal", mem[8'h80], 32'hAB223344);
    mem[8'hC0] = 32'h11223344;
    run_store(32'h302, 32'h0000CAFE, 2'd1, 2, 2, "half_wait");
    chk_eq("half literal", mem[8'hC0], 32'hCAFE3344);
    run_store(32'h401, 32'h12345678, 2'd1, 0, 0, "mis_half");
    run_store(32'h402, 32'h12345678, 2'd2, 0, 0, "mis_word");
    run_store(32'h040, 32'h12345678, 2'd3, 0, 0, "rsvd_size");
    run_store(32'h051, 32'h000000EE, 2'd0, 99, 0, "rd_timeout");
    run_store(32'h062, 32'h00005555, 2'd1, 0, 99, "wr_timeout");
    run_store(32'h070, 32'h01020304, 2'd2, 0, TO - 1, "ack_last_cycle");
    run_store(32'h081, 32'h000000C3, 2'd0, TO - 1, 1, "rd_ack_last");
    reset_in_write(32'h0A2);

    for (int k = 0; k < 40; k++) begin
      ra = 32'($urandom_range(0, 1023));
      rw = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      ww = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      run_store(ra, $urandom, 2'($urandom_range(0, 3)), rw, ww, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
